// File: rtl/host_ctrl_timing_unit.sv
// Host control/timing: delayed reset-done, gated host reset, cycle counter, small GPIO register.
// Latency: reset-done delayed chain_depth_p cycles; counter and GPIO registered (1 cycle); readback combinational.
// Backpressure: none; every input is sampled each cycle. Debug prints under HOST_CTRL_TIMING_DEBUG_EN.
module host_ctrl_timing_unit #(
    parameter int                      ctr_width_p       = 64,
    parameter int                      chain_depth_p     = 3,
    parameter int                      gpio_width_p      = 2,
    parameter logic [gpio_width_p-1:0] gpio_init_p       = '0,
    parameter logic [gpio_width_p-1:0] gpio_use_output_p = '1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    reset_done_i,
    output logic                    reset_done_r_o,
    output logic                    host_reset_o,
    input  logic                    ctr_clear_i,
    output logic [ctr_width_p-1:0]  ctr_r_o,
    input  logic                    gpio_w_v_i,
    input  logic [gpio_width_p-1:0] gpio_w_data_i,
    input  logic [gpio_width_p-1:0] gpio_w_mask_i,
    input  logic [gpio_width_p-1:0] gpio_i,
    output logic [gpio_width_p-1:0] gpio_o,
    output logic [gpio_width_p-1:0] gpio_r_o
);

    generate
        if (chain_depth_p == 0) begin : g_pass
            assign reset_done_r_o = reset_done_i;
        end else begin : g_chain
            logic [chain_depth_p-1:0] chain_q;
            logic [chain_depth_p-1:0] chain_d;

            always_comb begin
                chain_d    = chain_q;
                chain_d[0] = reset_done_i;
                for (int i = 1; i < chain_depth_p; i++) begin
                    chain_d[i] = chain_q[i-1];
                end
            end

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= chain_d;
                end
            end

            assign reset_done_r_o = chain_q[chain_depth_p-1];
        end
    endgenerate

    assign host_reset_o = reset_i | ~reset_done_r_o;

    logic [ctr_width_p-1:0] ctr_q;
    logic [ctr_width_p-1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q + 1'b1;
        if (ctr_clear_i) begin
            ctr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_r_o = ctr_q;

    // Input-select bits are forced to 0 so they never hold host-written state.
    logic [gpio_width_p-1:0] gpio_q;
    logic [gpio_width_p-1:0] gpio_d;

    always_comb begin
        gpio_d = gpio_q;
        if (gpio_w_v_i) begin
            gpio_d = (gpio_q & ~gpio_w_mask_i) | (gpio_w_data_i & gpio_w_mask_i);
        end
        gpio_d = gpio_d & gpio_use_output_p;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gpio_q <= gpio_init_p & gpio_use_output_p;
        end else begin
            gpio_q <= gpio_d;
        end
    end

    assign gpio_o   = gpio_q;
    assign gpio_r_o = (gpio_q & gpio_use_output_p) | (gpio_i & ~gpio_use_output_p);

`ifdef HOST_CTRL_TIMING_DEBUG_EN
    logic done_seen_q;
    logic [gpio_width_p-1:0] gpio_next;

    assign gpio_next = reset_i ? (gpio_init_p & gpio_use_output_p) : gpio_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_seen_q <= 1'b0;
        end else if (reset_done_r_o && !done_seen_q) begin
            done_seen_q <= 1'b1;
            $display("host_ctrl_timing_unit: reset_done_r rose at ctr=%0d", ctr_q);
        end
        if (gpio_next != gpio_q) begin
            $display("host_ctrl_timing_unit: gpio ctr=%0d old=%b new=%b", ctr_q, gpio_q, gpio_next);
        end
    end
`endif

endmodule

// File: tb/tb_host_ctrl_timing_unit.sv
// Randomized bench: two instances (depth 3 / 4-bit counter, depth 0 / mixed GPIO) against a cycle-history model.
module tb_host_ctrl_timing_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done = 1'b0;
    logic       clr = 1'b0;
    logic       wv = 1'b0;
    logic [1:0] wd = 2'b00;
    logic [1:0] wm = 2'b00;
    logic [1:0] gi = 2'b00;

    logic        rdr_a, hr_a, rdr_b, hr_b;
    logic [3:0]  ctr_a;
    logic [63:0] ctr_b;
    logic [1:0]  go_a, gr_a, go_b, gr_b;

    always #5 clk = ~clk;

    host_ctrl_timing_unit #(
        .ctr_width_p(4), .chain_depth_p(3), .gpio_width_p(2),
        .gpio_init_p(2'b00), .gpio_use_output_p(2'b11)
    ) dut_a (
        .clk_i(clk), .reset_i(rst), .reset_done_i(done), .reset_done_r_o(rdr_a),
        .host_reset_o(hr_a), .ctr_clear_i(clr), .ctr_r_o(ctr_a),
        .gpio_w_v_i(wv), .gpio_w_data_i(wd), .gpio_w_mask_i(wm), .gpio_i(gi),
        .gpio_o(go_a), .gpio_r_o(gr_a)
    );

    host_ctrl_timing_unit #(
        .ctr_width_p(64), .chain_depth_p(0), .gpio_width_p(2),
        .gpio_init_p(2'b11), .gpio_use_output_p(2'b01)
    ) dut_b (
        .clk_i(clk), .reset_i(rst), .reset_done_i(done), .reset_done_r_o(rdr_b),
        .host_reset_o(hr_b), .ctr_clear_i(clr), .ctr_r_o(ctr_b),
        .gpio_w_v_i(wv), .gpio_w_data_i(wd), .gpio_w_mask_i(wm), .gpio_i(gi),
        .gpio_o(go_b), .gpio_r_o(gr_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model state: per-edge history of sampled reset/done, counters, GPIO registers.
    bit          hist_r[$];
    bit          hist_d[$];
    int          cm_a = 0;
    logic [63:0] cm_b = 64'd0;
    logic [1:0]  gm_a = 2'b00;
    logic [1:0]  gm_b = 2'b00;
    int          nedge = 0;

    localparam logic [1:0] USE_A = 2'b11, INIT_A = 2'b00;
    localparam logic [1:0] USE_B = 2'b01, INIT_B = 2'b11;

    // A done sampled D edges ago survives only if no reset was sampled since it entered.
    function automatic bit exp_delayed(input int depth);
        int n = hist_r.size();
        if (n < depth) return 1'b0;
        for (int j = n - depth; j < n; j++) begin
            if (hist_r[j]) return 1'b0;
        end
        return hist_d[n-depth];
    endfunction

    function automatic logic [1:0] gpio_next(input logic [1:0] cur, input logic [1:0] use_m,
                                             input logic [1:0] init_m);
        logic [1:0] nx = cur;
        for (int b = 0; b < 2; b++) begin
            if (!use_m[b])                 nx[b] = 1'b0;
            else if (rst)                  nx[b] = init_m[b];
            else if (wv && wm[b])          nx[b] = wd[b];
        end
        return nx;
    endfunction

    task automatic step(input logic r, input logic d, input logic c, input logic v,
                        input logic [1:0] wdat, input logic [1:0] wmsk, input logic [1:0] gin);
        bit ea, eb;
        @(negedge clk);
        rst = r; done = d; clr = c; wv = v; wd = wdat; wm = wmsk; gi = gin;
        #1;
        if (nedge > 0) begin
            ea = exp_delayed(3);
            eb = done;
            chk("a_rdone", 64'(rdr_a), 64'(ea));
            chk("a_hrst",  64'(hr_a),  64'(rst | !ea));
            chk("a_ctr",   64'(ctr_a), 64'(cm_a));
            chk("a_gpo",   64'(go_a),  64'(gm_a));
            chk("a_gpr",   64'(gr_a),  64'(gm_a));
            chk("b_rdone", 64'(rdr_b), 64'(eb));
            chk("b_hrst",  64'(hr_b),  64'(rst | !eb));
            chk("b_ctr",   ctr_b,      cm_b);
            chk("b_gpo",   64'(go_b),  64'(gm_b));
            chk("b_gpr",   64'(gr_b),  64'({gi[1], gm_b[0]}));
        end
        @(posedge clk);
        hist_r.push_back(rst);
        hist_d.push_back(done);
        if (rst || clr) begin
            cm_a = 0;
            cm_b = 64'd0;
        end else begin
            cm_a = (cm_a + 1) % 16;
            cm_b = cm_b + 64'd1;
        end
        gm_a = gpio_next(gm_a, USE_A, INIT_A);
        gm_b = gpio_next(gm_b, USE_B, INIT_B);
        nedge++;
    endtask

    task automatic idle(input logic d, input int n);
        for (int i = 0; i < n; i++) step(1'b0, d, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        logic rd;
        rd = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        idle(1'b0, 6);
        idle(1'b1, 6);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, 2'b00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00);
        idle(1'b1, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 2'b11, 2'b10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
        for (int i = 0; i < 20 && cm_a != 7; i++) idle(1'b1, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        idle(1'b1, 3);
        idle(1'b0, 5);
        idle(1'b1, 1);
        idle(1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        idle(1'b0, 6);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'b11, 2'b00);
        idle(1'b1, 5);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rd = ~rd;
            step(($urandom_range(0, 63) == 0), rd, ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 2) == 0), 2'($urandom), 2'($urandom), 2'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
